// File: rtl/timer_peripheral_pkg.sv
// Shared register map and bit positions for the memory-mapped down-counting timer.
package timer_peripheral_pkg;

    // Word offsets inside the 0x1100-0x11ff window (low address byte).
    localparam int unsigned TMR_CTRL     = 32'h00;
    localparam int unsigned TMR_PRESCALE = 32'h01;
    localparam int unsigned TMR_RELOAD   = 32'h02;
    localparam int unsigned TMR_COUNT    = 32'h03;
    localparam int unsigned TMR_STATUS   = 32'h04;

    // CTRL bit positions.
    localparam int unsigned CTRL_EN          = 0;
    localparam int unsigned CTRL_AUTO_RELOAD = 1;
    localparam int unsigned CTRL_IRQ_EN      = 2;

    // STATUS bit positions.
    localparam int unsigned STATUS_EXPIRED = 0;

endpackage

// File: rtl/timer_peripheral_prescaler.sv
// Prescaler: emits a one-cycle tick every prescale+1 clocks while enabled.
module timer_prescaler
    import timer_peripheral_pkg::*;
#(
    parameter int BITS = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic [BITS-1:0] prescale,
    input  logic            clear,
    output logic            tick
);

    logic [BITS-1:0] pcnt;

    assign tick = enable && (pcnt == prescale);

    // Count up to prescale, wrap on tick; held at 0 while disabled or cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
        end else if (!enable || clear || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + {{(BITS-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/timer_peripheral.sv
// Memory-mapped 16-bit down-counting timer with prescaler, sticky expiry flag and level IRQ.
module timer_peripheral
    import timer_peripheral_pkg::*;
#(
    parameter int BITS      = 16,
    parameter int ADDR_BITS = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [ADDR_BITS-1:0] ADDRESS,
    input  logic [BITS-1:0]      DATA_IN,
    output logic [BITS-1:0]      DATA_OUT,
    input  logic                 WRb,
    output logic                 IRQ
);

    logic            en;
    logic            auto_reload;
    logic            irq_en;
    logic [BITS-1:0] prescale;
    logic [BITS-1:0] reload;
    logic [BITS-1:0] count;
    logic            expired;

    logic            wr_ctrl;
    logic            wr_prescale;
    logic            wr_reload;
    logic            wr_count;
    logic            wr_status;
    logic            tick;
    logic            expire;
    logic [BITS-1:0] rd_data;

    assign wr_ctrl     = !WRb && (ADDRESS == ADDR_BITS'(TMR_CTRL));
    assign wr_prescale = !WRb && (ADDRESS == ADDR_BITS'(TMR_PRESCALE));
    assign wr_reload   = !WRb && (ADDRESS == ADDR_BITS'(TMR_RELOAD));
    assign wr_count    = !WRb && (ADDRESS == ADDR_BITS'(TMR_COUNT));
    assign wr_status   = !WRb && (ADDRESS == ADDR_BITS'(TMR_STATUS));

    // A COUNT write restarts the prescale period as well as a PRESCALE write.
    timer_prescaler #(
        .BITS(BITS)
    ) u_prescaler (
        .clk      (CLK),
        .rst      (RST),
        .enable   (en),
        .prescale (prescale),
        .clear    (wr_prescale || wr_count),
        .tick     (tick)
    );

    assign expire = tick && (count == '0);

    // CTRL: CPU write wins over the one-shot clear of EN.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            en          <= 1'b0;
            auto_reload <= 1'b0;
            irq_en      <= 1'b0;
        end else if (wr_ctrl) begin
            en          <= DATA_IN[CTRL_EN];
            auto_reload <= DATA_IN[CTRL_AUTO_RELOAD];
            irq_en      <= DATA_IN[CTRL_IRQ_EN];
        end else if (expire && !auto_reload) begin
            en          <= 1'b0;
        end
    end

    // PRESCALE and RELOAD are plain CPU-written registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prescale <= '0;
            reload   <= '0;
        end else begin
            if (wr_prescale) prescale <= DATA_IN;
            if (wr_reload)   reload   <= DATA_IN;
        end
    end

    // COUNT: CPU write beats decrement/reload; stops at 0 in one-shot mode.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (wr_count) begin
            count <= DATA_IN;
        end else if (tick) begin
            if (count != '0) begin
                count <= count - {{(BITS-1){1'b0}}, 1'b1};
            end else if (auto_reload) begin
                count <= reload;
            end
        end
    end

    // EXPIRED is sticky; a new expiry wins over a write-1-to-clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            expired <= 1'b0;
        end else if (expire) begin
            expired <= 1'b1;
        end else if (wr_status && DATA_IN[STATUS_EXPIRED]) begin
            expired <= 1'b0;
        end
    end

    // Read mux over pre-update register state; unmapped offsets read 0.
    always_comb begin
        rd_data = '0;
        case (ADDRESS)
            ADDR_BITS'(TMR_CTRL): begin
                rd_data[CTRL_EN]          = en;
                rd_data[CTRL_AUTO_RELOAD] = auto_reload;
                rd_data[CTRL_IRQ_EN]      = irq_en;
            end
            ADDR_BITS'(TMR_PRESCALE): rd_data = prescale;
            ADDR_BITS'(TMR_RELOAD):   rd_data = reload;
            ADDR_BITS'(TMR_COUNT):    rd_data = count;
            ADDR_BITS'(TMR_STATUS):   rd_data[STATUS_EXPIRED] = expired;
            default:                  rd_data = '0;
        endcase
    end

    // Registered read data, one cycle latency like a synchronous RAM.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            DATA_OUT <= '0;
        end else begin
            DATA_OUT <= rd_data;
        end
    end

    assign IRQ = expired && irq_en;

endmodule

// File: tb/tb_timer_peripheral.sv
// Self-checking bench for timer_peripheral: directed scenarios plus random bus traffic
// compared against a cycle-level behavioural model of the register map.
module tb_timer_peripheral;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ADDRESS;
    logic [15:0] DATA_IN;
    logic [15:0] DATA_OUT;
    logic        WRb;
    logic        IRQ;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Behavioural model state.
    bit          m_en, m_ar, m_ie, m_expired;
    logic [15:0] m_pre, m_reload, m_count, m_pcnt;

    logic [15:0] exp_seq [6] = '{16'd4, 16'd3, 16'd2, 16'd1, 16'd0, 16'd4};

    timer_peripheral #(
        .BITS      (16),
        .ADDR_BITS (8)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .ADDRESS  (ADDRESS),
        .DATA_IN  (DATA_IN),
        .DATA_OUT (DATA_OUT),
        .WRb      (WRb),
        .IRQ      (IRQ)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_ar = 0; m_ie = 0; m_expired = 0;
        m_pre = 0; m_reload = 0; m_count = 0; m_pcnt = 0;
    endtask

    function automatic logic [15:0] m_read(input logic [7:0] a);
        case (a)
            8'h00:   return {13'd0, m_ie, m_ar, m_en};
            8'h01:   return m_pre;
            8'h02:   return m_reload;
            8'h03:   return m_count;
            8'h04:   return {15'd0, m_expired};
            default: return 16'h0000;
        endcase
    endfunction

    function automatic bit tick_next();
        return m_en && (m_pcnt == m_pre);
    endfunction

    // One bus cycle: drive, advance the model by one clock, check read data and IRQ.
    task automatic cycle(input bit wr, input logic [7:0] a, input logic [15:0] d);
        logic [15:0] exp_rd;
        bit tick, expire;
        WRb = ~wr; ADDRESS = a; DATA_IN = d;
        exp_rd = m_read(a);
        tick   = tick_next();
        expire = tick && (m_count == 0);
        // Prescaler period
        if (!m_en || tick) m_pcnt = 0;
        else               m_pcnt = m_pcnt + 1;
        // Counter event
        if (tick) begin
            if (m_count != 0) m_count = m_count - 1;
            else if (m_ar)    m_count = m_reload;
            else              m_en = 0;
        end
        if (expire) m_expired = 1;
        else if (wr && a == 8'h04 && d[0]) m_expired = 0;
        // CPU writes override timer-side updates
        if (wr) begin
            case (a)
                8'h00: begin m_en = d[0]; m_ar = d[1]; m_ie = d[2]; end
                8'h01: begin m_pre = d; m_pcnt = 0; end
                8'h02: m_reload = d;
                8'h03: begin m_count = d; m_pcnt = 0; end
                default: ;
            endcase
        end
        @(posedge clk); #1;
        cyc++;
        check_eq($sformatf("rdata@%0h", a), DATA_OUT, exp_rd);
        check_eq("irq", IRQ, m_expired & m_ie);
        WRb = 1'b1;
    endtask

    initial begin
        logic [15:0] seq[$];
        int          rel_cyc[$];
        logic [15:0] prev;
        logic [7:0]  a;
        logic [15:0] d;
        bit          w;

        rst = 1'b1; WRb = 1'b1; ADDRESS = 8'h00; DATA_IN = 16'h0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_dout", DATA_OUT, 16'h0000);
        check_eq("reset_irq", IRQ, 1'b0);
        #3 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle(0, 8'(i), 16'h0);
        end

        // Read latency and unmapped offsets
        cycle(1, 8'h03, 16'hBEEF);
        check_eq("count_old_on_write", DATA_OUT, 16'h0000);
        cycle(0, 8'h03, 16'h0);
        check_eq("count_beef", DATA_OUT, 16'hBEEF);
        cycle(1, 8'h07, 16'h1234);
        cycle(0, 8'h07, 16'h0);
        check_eq("unmapped_07", DATA_OUT, 16'h0000);

        // One-shot
        cycle(1, 8'h01, 16'h0000);
        cycle(1, 8'h03, 16'h0002);
        cycle(1, 8'h00, 16'h0001);
        repeat (5) cycle(0, 8'h04, 16'h0);
        cycle(0, 8'h00, 16'h0);
        check_eq("oneshot_ctrl", DATA_OUT, 16'h0000);
        cycle(0, 8'h03, 16'h0);
        check_eq("oneshot_count", DATA_OUT, 16'h0000);
        cycle(0, 8'h04, 16'h0);
        check_eq("oneshot_status", DATA_OUT, 16'h0001);

        // IRQ masking
        check_eq("irq_masked", IRQ, 1'b0);
        cycle(1, 8'h00, 16'h0004);
        check_eq("irq_unmasked", IRQ, 1'b1);
        cycle(1, 8'h04, 16'h0001);
        check_eq("irq_cleared", IRQ, 1'b0);

        // Periodic: interval (4+1)*(3+1) = 20 clocks
        cycle(1, 8'h00, 16'h0000);
        cycle(1, 8'h01, 16'h0003);
        cycle(1, 8'h02, 16'h0004);
        cycle(1, 8'h03, 16'h0004);
        cycle(1, 8'h00, 16'h0007);
        prev = 16'hFFFF;
        for (int i = 0; i < 50; i++) begin
            cycle(0, 8'h03, 16'h0);
            if (seq.size() == 0 || DATA_OUT != seq[$]) seq.push_back(DATA_OUT);
            if (prev == 16'h0000 && DATA_OUT == 16'h0004) rel_cyc.push_back(cyc);
            prev = DATA_OUT;
        end
        check_eq("periodic_seq_len_ok", seq.size() >= 6, 1'b1);
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("periodic_seq%0d", i),
                     (seq.size() > i) ? seq[i] : 16'hDEAD, exp_seq[i]);
        end
        check_eq("periodic_interval",
                 (rel_cyc.size() >= 2) ? (rel_cyc[1] - rel_cyc[0]) : 0, 20);

        // COUNT write on a tick edge: write wins and prescaler restarts
        cycle(1, 8'h00, 16'h0000);
        cycle(1, 8'h04, 16'h0001);
        cycle(1, 8'h01, 16'h0003);
        cycle(1, 8'h03, 16'h0008);
        cycle(1, 8'h00, 16'h0001);
        for (int i = 0; i < 50 && !tick_next(); i++) cycle(0, 8'h03, 16'h0);
        check_eq("reach_tick", tick_next(), 1'b1);
        cycle(1, 8'h03, 16'h0010);
        repeat (3) cycle(0, 8'h03, 16'h0);
        cycle(0, 8'h03, 16'h0);
        check_eq("count_hold_4th", DATA_OUT, 16'h0010);
        cycle(0, 8'h03, 16'h0);
        check_eq("count_dec_after_4", DATA_OUT, 16'h000F);

        // STATUS clear on the same edge as an expiry
        cycle(1, 8'h00, 16'h0000);
        cycle(1, 8'h01, 16'h0000);
        cycle(1, 8'h02, 16'h0002);
        cycle(1, 8'h03, 16'h0001);
        cycle(1, 8'h00, 16'h0003);
        for (int i = 0; i < 50 && !(tick_next() && m_count == 0); i++) cycle(0, 8'h03, 16'h0);
        check_eq("reach_expiry", tick_next() && m_count == 0, 1'b1);
        cycle(1, 8'h04, 16'h0001);
        cycle(0, 8'h04, 16'h0);
        check_eq("status_collision", DATA_OUT, 16'h0001);

        // Asynchronous reset mid-count
        cycle(1, 8'h01, 16'h0001);
        cycle(1, 8'h03, 16'h0005);
        cycle(1, 8'h00, 16'h0005);
        repeat (3) cycle(0, 8'h03, 16'h0);
        check_eq("irq_before_reset", IRQ, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_dout", DATA_OUT, 16'h0000);
        check_eq("async_rst_irq", IRQ, 1'b0);
        model_reset();
        @(posedge clk);
        #3 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle(0, 8'(i), 16'h0);
            check_eq($sformatf("post_rst_reg%0d", i), DATA_OUT, 16'h0000);
        end
        repeat (10) cycle(0, 8'h03, 16'h0);
        check_eq("no_ticks_after_rst", DATA_OUT, 16'h0000);

        // Random bus traffic against the model
        for (int i = 0; i < 400; i++) begin
            w = ($urandom_range(0, 3) == 0);
            a = 8'($urandom_range(0, 7));
            case (a)
                8'h01:        d = 16'($urandom_range(0, 3));
                8'h02, 8'h03: d = 16'($urandom_range(0, 9));
                default:      d = 16'($urandom);
            endcase
            cycle(w, a, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_peripheral.md
Name: timer_peripheral

Overview:
- Memory-mapped 16-bit down-counting timer with prescaler and interrupt output. Occupies the 0x1100–0x11ff window.
- The memory controller decodes that window, gates the write strobe, passes ADDRESS[7:0] and DATA_IN, and muxes this block's read data onto the CPU bus.
- Provides periodic or one-shot tick events and a level IRQ for the CPU.

Parameters:
- BITS, 16, data bus width; registers are BITS wide.
- ADDR_BITS, 8, width of local register address (low byte of bus address).

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RST  in  1  reset is asynchronous and active-high.
- ADDRESS  in  ADDR_BITS  register offset within window.
- DATA_IN  in  BITS  write data.
- DATA_OUT  out  BITS  registered read data.
- WRb  in  1  active-low write strobe, already gated by window decode.
- IRQ  out  1  level interrupt, high while EXPIRED and IRQ_EN.

Behaviour:
- Register map, word offsets; unmapped offsets read 0 and ignore writes:
  - 0x00 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN; upper bits read 0.
  - 0x01 PRESCALE: a tick occurs every PRESCALE+1 clocks while EN.
  - 0x02 RELOAD: value loaded into COUNT on expiry when AUTO_RELOAD=1.
  - 0x03 COUNT: read gives the live count; a write loads COUNT directly.
  - 0x04 STATUS: bit0 EXPIRED, sticky; writing 1 to bit0 clears it, writing 0 has no effect.
- Reset (async, RST=1): all registers 0, prescaler counter 0, DATA_OUT=0, IRQ=0.
- Write: when WRb=0 at a rising CLK, the addressed register is updated from DATA_IN at that edge.
- Read: DATA_OUT is loaded at every rising edge with the value of the register at ADDRESS. Latency is 1 cycle, matching synchronous RAM/ROM.
  - The read captures register state before any same-edge update. A read of COUNT during a write edge returns the old COUNT.
- Prescaler:
  - 16-bit counter PCNT. While EN=0, PCNT is held at 0.
  - While EN=1: if PCNT==PRESCALE then tick=1 and PCNT<=0; otherwise PCNT<=PCNT+1.
  - PRESCALE=0 gives a tick every clock.
- Counter, on each tick with EN=1:
  - If COUNT!=0: COUNT<=COUNT-1.
  - If COUNT==0 (expiry): EXPIRED<=1.
    - AUTO_RELOAD=1: COUNT<=RELOAD.
    - AUTO_RELOAD=0: COUNT stays 0 and EN<=0 (one-shot; the CTRL bit itself is cleared).
  - Resulting periodic interval: (RELOAD+1)*(PRESCALE+1) clocks.
- Precedence on the same edge:
  - CPU write to COUNT beats tick decrement/reload; PCNT is also reset to 0.
  - CPU write to PRESCALE resets PCNT to 0.
  - CPU write to CTRL beats the one-shot auto-clear of EN.
  - New expiry beats a STATUS clear: EXPIRED ends at 1.
- IRQ = EXPIRED & IRQ_EN, derived from registered state with no combinational path from inputs.
- Wrap-around: COUNT never underflows past 0; PCNT never exceeds PRESCALE. If PRESCALE is written below the current PCNT, the PCNT reset on that write covers it.

Decomposition:
- Shared package holds:
  - Register offsets TMR_CTRL=0x00, TMR_PRESCALE=0x01, TMR_RELOAD=0x02, TMR_COUNT=0x03, TMR_STATUS=0x04.
  - CTRL bit indices EN=0, AUTO_RELOAD=1, IRQ_EN=2.
  - STATUS bit EXPIRED=0.
- One natural sub-module: timer_prescaler. Inputs CLK, RST, enable, PRESCALE, clear; output single-cycle tick.

Test Plan:
- Reset mid-count: COUNT=0x0005 running, assert RST asynchronously -> all reads return 0x0000, IRQ=0, no further ticks after release.
- Periodic: PRESCALE=3, RELOAD=4, COUNT=4, CTRL=0x0007 -> EXPIRED sets every 20 clocks; COUNT sequence 4,3,2,1,0,4; IRQ rises 1 cycle after the expiry edge.
- One-shot: PRESCALE=0, COUNT=2, CTRL=0x0001 -> expiry at the 3rd tick; CTRL reads 0x0000 afterwards; COUNT stays 0; STATUS=0x0001.
- Read latency and unmapped offsets: write COUNT=0xBEEF then read offset 0x03 -> DATA_OUT=0xBEEF one cycle after address is presented; offset 0x07 reads 0x0000.
- Collisions: STATUS write 0x0001 on the same edge as an expiry -> STATUS=0x0001. COUNT write 0x0010 on a tick edge -> COUNT=0x0010 and PCNT restarts from 0.
- IRQ masking: EXPIRED=1 with IRQ_EN=0 -> IRQ=0; set IRQ_EN -> IRQ=1 next cycle; write STATUS 0x0001 -> IRQ=0.
